// File: rtl/i2c_pkg.sv
// Shared I2C definitions.
// Holds the bus field widths and the 3-bit state encoding used by the
// bus-protocol FSMs. i2c_master uses the same state names.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;

    // Target-side protocol states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_BYTE   = 3'd3,
        RX_ACK    = 3'd4,
        TX_BYTE   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus input conditioner.
// Synchronises asynchronous SCL/SDA into the clk_i domain, then compares the
// last synchroniser stage against one extra delay flop to produce single-cycle
// edge and bus-condition events.
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset (all flops preset to 1 = idle bus)
//   scl_i/sda_i  raw bus levels
//   sda_o        synchronised SDA level
//   scl_rise_o   SCL 0->1
//   scl_fall_o   SCL 1->0
//   start_det_o  SDA 1->0 while SCL high
//   stop_det_o   SDA 0->1 while SCL high
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_dly_q;
    logic                   sda_dly_q;
    logic                   scl_s;
    logic                   sda_s;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
            sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o       = sda_s;
    assign scl_rise_o  = scl_s & ~scl_dly_q;
    assign scl_fall_o  = ~scl_s & scl_dly_q;
    // SCL must be high on both samples so an SDA change next to an SCL edge
    // is never taken as a bus condition.
    assign start_det_o = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address.
// Oversamples the bus, ACKs its own address, hands written bytes to the fabric
// and serves read bytes from it. SDA is open-drain (sda_oe=1 pulls low); SCL is
// never stretched.
//
// Ports:
//   clk_in    system clock (>= 8x SCL)
//   rst_in    synchronous active-low reset
//   scl_in    bus SCL level
//   sda_in    bus SDA level
//   sda_oe    1 = pull SDA low
//   rx_data   last byte written by the master
//   rx_valid  one-cycle strobe, rx_data is new
//   tx_data   next byte to return on a read, sampled on tx_ack
//   tx_ack    one-cycle strobe, tx_data has been latched
//   busy      high from an address-matched START until STOP
//   rw_out    R/W bit of the current matched transaction (1 = read)
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_DATA_W-1:0] tx_data,
    output logic                  tx_ack,
    output logic                  busy,
    output logic                  rw_out
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det)
    );

    i2c_state_e            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [I2C_DATA_W-1:0] shift_q, shift_d;
    logic [I2C_DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [I2C_DATA_W-1:0] rx_data_q, rx_data_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_ack_q, tx_ack_d;
    logic                  busy_q, busy_d;
    logic                  rw_q, rw_d;
    // Set once the current byte (or master ACK) has been sampled; the state
    // then waits for the following scl_fall to move on.
    logic                  done_q, done_d;
    logic [I2C_DATA_W-1:0] shift_in;

    assign shift_in = {shift_q[I2C_DATA_W-2:0], sda_s};

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd7;
            shift_q    <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            tx_ack_q   <= tx_ack_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        rx_valid_d = 1'b0;
        tx_ack_d   = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        done_d     = done_q;

        if (start_det) begin
            // Also covers repeated START; any partial byte is dropped.
            state_d  = ADDR;
            cnt_d    = 3'd7;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end

                ADDR: begin
                    if (scl_rise && !done_q) begin
                        shift_d = shift_in;
                        if (cnt_q == 3'd0) begin
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                rw_d   = shift_in[0];
                                busy_d = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                state_d  = WAIT_STOP;
                                sda_oe_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall && done_q) begin
                        sda_oe_d = 1'b1;
                        done_d   = 1'b0;
                        state_d  = ADDR_ACK;
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 3'd7;
                        if (rw_q) begin
                            tx_shift_d = tx_data;
                            tx_ack_d   = 1'b1;
                            sda_oe_d   = ~tx_data[7];
                            state_d    = TX_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = RX_BYTE;
                        end
                    end
                end

                RX_BYTE: begin
                    if (scl_rise && !done_q) begin
                        shift_d = shift_in;
                        if (cnt_q == 3'd0) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall && done_q) begin
                        sda_oe_d = 1'b1;
                        done_d   = 1'b0;
                        state_d  = RX_ACK;
                    end
                end

                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd7;
                        state_d  = RX_BYTE;
                    end
                end

                TX_BYTE: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            done_d   = 1'b0;
                            state_d  = TX_ACK;
                        end else begin
                            tx_shift_d = {tx_shift_q[I2C_DATA_W-2:0], 1'b0};
                            sda_oe_d   = ~tx_shift_q[6];
                            cnt_d      = cnt_q - 3'd1;
                        end
                    end
                end

                TX_ACK: begin
                    if (scl_rise && !done_q) begin
                        if (!sda_s) begin
                            done_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end else if (scl_fall && done_q) begin
                        tx_shift_d = tx_data;
                        tx_ack_d   = 1'b1;
                        sda_oe_d   = ~tx_data[7];
                        cnt_d      = 3'd7;
                        done_d     = 1'b0;
                        state_d    = TX_BYTE;
                    end
                end

                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Gated by reset so SDA is released in the same cycle reset is asserted.
    assign sda_oe   = sda_oe_q & rst_in;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ack   = tx_ack_q;
    assign busy     = busy_q;
    assign rw_out   = rw_q;

endmodule
